elevator_ctrl_n: RTL and testbench
==================================

Name: elevator_ctrl_n

Overview:
- Parametrised N-floor elevator controller; next generation of the 3-floor elevator block.
- Adds latched multi-floor requests, collective (SCAN) scheduling, a door dwell timer with hold and re-open, and a binary current-floor output.
- Sits between the floor-button and shaft-sensor inputs and the floor-indicator, motor-direction and door outputs.
- Shaft sensor delivers one floor_arrived pulse per floor crossed.

Parameters:
- NUM_FLOORS, 8: number of floors, minimum 2; floor 0 is the bottom floor.
- DOOR_CYCLES, 4: clock cycles the door stays open with no re-press and no hold; minimum 1.
- FL_W, $clog2(NUM_FLOORS): width of the floor index (derived localparam).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- floor_button  in  NUM_FLOORS  request pulses, one bit per floor; several bits may be set in the same cycle.
- floor_arrived  in  1  one-cycle pulse: car has reached the next floor in the current travel direction.
- door_hold  in  1  level input; while high, the open door does not start its close countdown.
- floor_led  out  NUM_FLOORS  one-hot indicator of the current floor.
- cur_floor  out  FL_W  binary index of the current floor.
- elevator_direction  out  2  motion command: 00 stationary, 01 up, 10 down; 11 is never driven.
- door_open  out  1  door command.
- req_pending  out  NUM_FLOORS  latched requests not yet served.

Behaviour:
- Reset: state IDLE, cur_floor=0, floor_led=1, elevator_direction=00, door_open=0, req_pending=0, last_dir=UP, door counter=0. A reset mid-move or with the door open drops all requests.
- All outputs are registered. pend = req_q | floor_button, evaluated in the current cycle.
- Request latch: req_q <= pend & ~served. served is the cur_floor bit whenever the next state is DOOR_OPEN.
- A press on the current floor while the door is open is never latched.
- Terms: above = any pend bit greater than cur_floor; below = any pend bit less than cur_floor; here = pend[cur_floor].
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE transitions:
  - here: go to DOOR_OPEN. door_open rises after the same edge that sampled the button (latency 1 edge).
  - else direction chosen by last_dir: if last_dir=UP, above goes to MOVE_UP, otherwise below goes to MOVE_DOWN. If last_dir=DOWN, below is tried first, then above.
  - else stay IDLE.
  - floor_arrived is ignored in IDLE.
- MOVE_UP: elevator_direction=01; last_dir=UP. On floor_arrived:
  - cur_floor increments and floor_led shifts left.
  - If pend has the new floor's bit set, go to DOOR_OPEN on the same edge.
  - Else if no pend bit remains above the new floor, go to IDLE (safety net).
  - Without a pulse, hold state.
  - At NUM_FLOORS-1, floor_arrived is ignored (cur_floor saturates) and the state goes to IDLE.
- MOVE_DOWN: mirror of MOVE_UP; elevator_direction=10; decrement; saturates at 0.
- DOOR_OPEN: elevator_direction=00; door_open=1.
  - On entry the counter loads DOOR_CYCLES-1.
  - The counter reloads while door_hold=1 or while floor_button[cur_floor]=1.
  - Otherwise it decrements each cycle.
  - When the counter is 0 and it is not reloading, door_open falls on the next edge. Without hold or re-press, door_open is high for exactly DOOR_CYCLES cycles.
- Leaving DOOR_OPEN: continue in last_dir if requests remain on that side; else reverse if requests remain on the other side; else IDLE.
- The next MOVE state is entered on the same edge door_open falls; elevator_direction becomes non-zero on that edge.
- Interlock: door_open=1 and elevator_direction!=00 are never true in the same cycle.
- Simultaneous events:
  - floor_arrived together with a button for the arrival floor: the car stops there.
  - A button for the floor just passed is latched and served on the return trip.
  - Requests in both directions: the current sweep is served first.

Decomposition:
- Package elevator_pkg holds:
  - DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10;
  - the state enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN};
  - helper functions any_above(mask, idx) and any_below(mask, idx).
- One sub-module, elevator_door_timer: loadable down-counter with a reload input and a done output, parameter DOOR_CYCLES.

Test Plan (NUM_FLOORS=4, DOOR_CYCLES=3):
- Reset, then idle for 5 cycles -> cur_floor=0, floor_led=0001, direction 00, door_open 0, req_pending 0.
- Press button 0 at floor 0 -> door_open high exactly 3 cycles, then IDLE; req_pending stays 0.
- Press button 2; two floor_arrived pulses 4 cycles apart -> direction 01; cur_floor goes 1, then 2; on the second pulse the state is DOOR_OPEN, direction 00, and req_pending[2] is cleared.
- At floor 2 with the door open, press 3 and 0 together -> after the door closes, direction 01 first. After the stop at floor 3, direction 10 with no intermediate stops; final cur_floor=0 and req_pending=0.
- Hold door_hold for 10 cycles with the door open, and re-press the current floor on the last counter cycle -> door_open stays high through the hold plus 3 cycles after the last re-press. Direction never becomes non-zero while door_open=1.
- Assert rst while in MOVE_UP with requests pending -> next edge: all reset values, req_pending=0; later floor_arrived pulses are ignored.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the N-floor elevator controller.
// Direction codes, FSM state encoding and request-mask scans.
package elevator_pkg;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Widest request mask the helpers accept; callers zero-extend.
    localparam int MAX_FLOORS = 64;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    function automatic logic any_above(
        input logic [MAX_FLOORS-1:0] mask,
        input int                    idx
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i > idx && mask[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(
        input logic [MAX_FLOORS-1:0] mask,
        input int                    idx
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < idx && mask[i]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/elevator_door_timer.sv
// Door dwell down-counter: load on entry, reload on hold/re-press.
// done is high on the last open cycle when no reload is requested.
module elevator_door_timer #(
    parameter int DOOR_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    input  logic reload,
    output logic done
);

    localparam int CW = $clog2(DOOR_CYCLES + 1);
    localparam logic [CW-1:0] INIT = CW'(DOOR_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: entry/reload restart the dwell, otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (load || (en && reload)) begin
            cnt_d = INIT;
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done = en && !reload && (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor collective (SCAN) elevator controller.
// Latches floor requests, sweeps in one direction, dwells with door.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS  = 8,
    parameter  int DOOR_CYCLES = 4,
    localparam int FL_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] floor_button,
    input  logic                  floor_arrived,
    input  logic                  door_hold,
    output logic [NUM_FLOORS-1:0] floor_led,
    output logic [FL_W-1:0]       cur_floor,
    output logic [1:0]            elevator_direction,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] req_pending
);

    localparam logic [FL_W-1:0] TOP = FL_W'(NUM_FLOORS - 1);

    state_t                state_q, state_d;
    logic [FL_W-1:0]       cur_q, cur_d;
    logic [NUM_FLOORS-1:0] led_q, led_d;
    logic [NUM_FLOORS-1:0] req_q, req_d;
    logic [1:0]            dir_q, dir_d;
    logic [1:0]            last_q, last_d;
    logic                  door_q, door_d;

    logic [NUM_FLOORS-1:0] pend;
    logic [NUM_FLOORS-1:0] served;
    logic [FL_W-1:0]       nxt_up, nxt_dn;
    logic                  here, above, below;
    logic                  go_up, go_dn;
    logic                  t_load, t_en, t_reload, t_done;

    assign t_en     = (state_q == DOOR_OPEN);
    assign t_reload = door_hold || floor_button[cur_q];
    assign t_load   = (state_d == DOOR_OPEN) && (state_q != DOOR_OPEN);

    elevator_door_timer #(
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (t_load),
        .en    (t_en),
        .reload(t_reload),
        .done  (t_done)
    );

    // Request view, sweep choice, next state and registered outputs.
    always_comb begin
        pend   = req_q | floor_button;
        here   = pend[cur_q];
        above  = any_above(MAX_FLOORS'(pend), int'(cur_q));
        below  = any_below(MAX_FLOORS'(pend), int'(cur_q));
        nxt_up = cur_q + FL_W'(1);
        nxt_dn = cur_q - FL_W'(1);

        go_up = (last_q == DIR_UP) ? above : (above && !below);
        go_dn = (last_q == DIR_UP) ? (below && !above) : below;

        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (here)       state_d = DOOR_OPEN;
                else if (go_up) state_d = MOVE_UP;
                else if (go_dn) state_d = MOVE_DOWN;
            end
            MOVE_UP: begin
                if (cur_q == TOP) begin
                    state_d = IDLE;
                end else if (floor_arrived) begin
                    cur_d = nxt_up;
                    if (pend[nxt_up]) begin
                        state_d = DOOR_OPEN;
                    end else if (!any_above(MAX_FLOORS'(pend),
                                            int'(nxt_up))) begin
                        state_d = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (cur_q == '0) begin
                    state_d = IDLE;
                end else if (floor_arrived) begin
                    cur_d = nxt_dn;
                    if (pend[nxt_dn]) begin
                        state_d = DOOR_OPEN;
                    end else if (!any_below(MAX_FLOORS'(pend),
                                            int'(nxt_dn))) begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                if (t_done) begin
                    if (go_up)      state_d = MOVE_UP;
                    else if (go_dn) state_d = MOVE_DOWN;
                    else            state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == MOVE_UP)   last_d = DIR_UP;
        if (state_d == MOVE_DOWN) last_d = DIR_DOWN;

        served = '0;
        if (state_d == DOOR_OPEN) served[cur_d] = 1'b1;
        req_d = pend & ~served;

        led_d        = '0;
        led_d[cur_d] = 1'b1;

        dir_d = DIR_IDLE;
        if (state_d == MOVE_UP)   dir_d = DIR_UP;
        if (state_d == MOVE_DOWN) dir_d = DIR_DOWN;
        door_d = (state_d == DOOR_OPEN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            led_q   <= NUM_FLOORS'(1);
            req_q   <= '0;
            dir_q   <= DIR_IDLE;
            last_q  <= DIR_UP;
            door_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            led_q   <= led_d;
            req_q   <= req_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
            door_q  <= door_d;
        end
    end

    assign floor_led          = led_q;
    assign cur_floor          = cur_q;
    assign elevator_direction = dir_q;
    assign door_open          = door_q;
    assign req_pending        = req_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Randomised bench for elevator_ctrl_n against a floor-level model.
// Directed scenarios first, then a long random run with resets.
module tb_elevator_ctrl_n;

    localparam int NF = 4;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] floor_button = '0;
    logic          floor_arrived = 1'b0;
    logic          door_hold = 1'b0;
    logic [NF-1:0] floor_led;
    logic [1:0]    cur_floor;
    logic [1:0]    elevator_direction;
    logic          door_open;
    logic [NF-1:0] req_pending;

    elevator_ctrl_n #(
        .NUM_FLOORS (NF),
        .DOOR_CYCLES(DC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .floor_button      (floor_button),
        .floor_arrived     (floor_arrived),
        .door_hold         (door_hold),
        .floor_led         (floor_led),
        .cur_floor         (cur_floor),
        .elevator_direction(elevator_direction),
        .door_open         (door_open),
        .req_pending       (req_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: floor number, motion -1/0/+1, open cycles left, sweep.
    int            m_floor;
    int            m_motion;
    int            m_door;
    int            m_last;
    logic [NF-1:0] m_req;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit side(input logic [NF-1:0] p, input int f,
                                input int s);
        for (int i = f + s; i >= 0 && i < NF; i += s)
            if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic [NF-1:0] btn, input bit arr,
                              input bit hold, input bit r);
        logic [NF-1:0] p;
        int nf, nm, nd;
        if (r) begin
            m_floor = 0; m_motion = 0; m_door = 0;
            m_last = 1; m_req = '0;
            return;
        end
        p  = m_req | btn;
        nf = m_floor; nm = m_motion; nd = m_door;
        if (m_door > 0) begin
            if (hold || btn[m_floor]) nd = DC;
            else if (m_door > 1) nd = m_door - 1;
            else begin
                nd = 0;
                if (side(p, m_floor, m_last)) nm = m_last;
                else if (side(p, m_floor, -m_last)) nm = -m_last;
                else nm = 0;
            end
        end else if (m_motion != 0) begin
            if ((m_motion > 0 && m_floor == NF - 1) ||
                (m_motion < 0 && m_floor == 0)) begin
                nm = 0;
            end else if (arr) begin
                nf = m_floor + m_motion;
                if (p[nf]) begin
                    nm = 0; nd = DC;
                end else if (!side(p, nf, m_motion)) begin
                    nm = 0;
                end
            end
        end else begin
            if (p[m_floor]) nd = DC;
            else if (side(p, m_floor, m_last)) nm = m_last;
            else if (side(p, m_floor, -m_last)) nm = -m_last;
        end
        if (nm != 0) m_last = nm;
        if (nd > 0) p[nf] = 1'b0;
        m_floor = nf; m_motion = nm; m_door = nd; m_req = p;
    endtask

    function automatic logic [1:0] m_dir();
        if (m_motion > 0) return 2'b01;
        if (m_motion < 0) return 2'b10;
        return 2'b00;
    endfunction

    task automatic cycle(input logic [NF-1:0] btn, input bit arr,
                         input bit hold, input bit r);
        logic [NF-1:0] led;
        floor_button  = btn;
        floor_arrived = arr;
        door_hold     = hold;
        rst           = r;
        @(posedge clk);
        model_step(btn, arr, hold, r);
        @(negedge clk);
        led = '0;
        led[m_floor] = 1'b1;
        chk("cur_floor", 32'(cur_floor), 32'(m_floor));
        chk("floor_led", 32'(floor_led), 32'(led));
        chk("direction", 32'(elevator_direction), 32'(m_dir()));
        chk("door_open", 32'(door_open), 32'(m_door > 0));
        chk("req_pending", 32'(req_pending), 32'(m_req));
        chk("interlock",
            32'(door_open && elevator_direction != 2'b00), 32'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b0, 1'b0);
    endtask

    int n;
    int k;
    int stops;
    logic prev_door;

    initial begin
        @(negedge clk);
        cycle('0, 1'b0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b0, 1'b1);
        idle(5);
        chk("rst_cur", 32'(cur_floor), 32'(0));
        chk("rst_led", 32'(floor_led), 32'(4'b0001));
        chk("rst_dir", 32'(elevator_direction), 32'(0));
        chk("rst_door", 32'(door_open), 32'(0));
        chk("rst_req", 32'(req_pending), 32'(0));

        n = 0;
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        if (door_open) n++;
        chk("here_req", 32'(req_pending), 32'(0));
        for (int i = 0; i < 7; i++) begin
            idle(1);
            if (door_open) n++;
        end
        chk("dwell_len", 32'(n), 32'(DC));

        cycle(4'b0100, 1'b0, 1'b0, 1'b0);
        chk("go_up_dir", 32'(elevator_direction), 32'(2'b01));
        idle(3);
        cycle('0, 1'b1, 1'b0, 1'b0);
        chk("pass_f1", 32'(cur_floor), 32'(1));
        idle(3);
        cycle('0, 1'b1, 1'b0, 1'b0);
        chk("stop_f2", 32'(cur_floor), 32'(2));
        chk("stop_door", 32'(door_open), 32'(1));
        chk("stop_dir", 32'(elevator_direction), 32'(0));
        chk("stop_req2", 32'(req_pending[2]), 32'(0));

        cycle(4'b1001, 1'b0, 1'b0, 1'b0);
        k = 0; stops = 0; prev_door = door_open;
        for (int i = 0; i < 60; i++) begin
            if (m_motion != 0) k++;
            cycle('0, (m_motion != 0) && (k % 4 == 3), 1'b0, 1'b0);
            if (door_open && !prev_door) stops++;
            prev_door = door_open;
        end
        chk("sweep_stops", 32'(stops), 32'(2));
        chk("sweep_cur", 32'(cur_floor), 32'(0));
        chk("sweep_req", 32'(req_pending), 32'(0));

        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle('0, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("hold_still_open", 32'(door_open), 32'(1));
        n = 0;
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        if (door_open) n++;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (door_open) n++;
        end
        chk("repress_len", 32'(n), 32'(DC));

        cycle(4'b1000, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle('0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_cur", 32'(cur_floor), 32'(1));
        cycle('0, 1'b0, 1'b0, 1'b1);
        chk("mrst_cur", 32'(cur_floor), 32'(0));
        chk("mrst_led", 32'(floor_led), 32'(4'b0001));
        chk("mrst_dir", 32'(elevator_direction), 32'(0));
        chk("mrst_door", 32'(door_open), 32'(0));
        chk("mrst_req", 32'(req_pending), 32'(0));
        for (int i = 0; i < 4; i++) cycle('0, 1'b1, 1'b0, 1'b0);
        chk("ign_arr_cur", 32'(cur_floor), 32'(0));
        chk("ign_arr_dir", 32'(elevator_direction), 32'(0));

        for (int i = 0; i < 3000; i++) begin
            logic [NF-1:0] b;
            bit a, h, r;
            b = ($urandom_range(0, 4) == 0) ?
                NF'($urandom_range(1, (1 << NF) - 1)) : '0;
            a = (m_motion != 0) ? ($urandom_range(0, 2) == 0)
                                : ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 399) == 0);
            cycle(b, a, h, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
